// File: rtl/kpn_pkg.sv
// Shared definitions for the Kahn-network actors: token/counter widths and
// the add-process state encoding.
package kpn_pkg;

    localparam int KPN_TOKEN_WIDTH = 16;
    localparam int KPN_CNT_WIDTH   = 16;

    typedef enum logic [2:0] {
        FETCH_A,
        LATCH_A,
        FETCH_B,
        LATCH_B,
        EMIT
    } kpn_add_state_t;

endpackage

// File: rtl/kpn_add_core.sv
// Combinational WIDTH-bit unsigned adder with carry out.
// Define KPN_ADD_SATURATE_EN to clamp the sum to all-ones on carry.
module kpn_add_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0] full_sum;

    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b};
        carry    = full_sum[WIDTH];
`ifdef KPN_ADD_SATURATE_EN
        sum      = carry ? '1 : full_sum[WIDTH-1:0];
`else
        sum      = full_sum[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/kpn_add_process.sv
// KPN actor: blocking-read A, blocking-read B, write A+B to the output FIFO.
// Saturating sums are selected by KPN_ADD_SATURATE_EN (see kpn_add_core).
module kpn_add_process
    import kpn_pkg::*;
#(
    parameter int WIDTH = KPN_TOKEN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     empty_a,
    input  logic [WIDTH-1:0]         data_a,
    output logic                     rd_a,
    input  logic                     empty_b,
    input  logic [WIDTH-1:0]         data_b,
    output logic                     rd_b,
    input  logic                     full_out,
    output logic                     wr_out,
    output logic [WIDTH-1:0]         data_out,
    output logic [KPN_CNT_WIDTH-1:0] token_cnt,
    output logic                     ovf,
    output logic                     busy
);

    kpn_add_state_t   state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] core_sum;
    logic             core_carry;

    kpn_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (a_reg),
        .b     (data_b),
        .sum   (core_sum),
        .carry (core_carry)
    );

    // Strobes only depend on the flag of the state that owns them, so each
    // strobe lasts exactly the one cycle in which the transition is taken.
    always_comb begin
        rd_a   = (state == FETCH_A) && !empty_a;
        rd_b   = (state == FETCH_B) && !empty_b;
        wr_out = (state == EMIT)    && !full_out;
    end

    assign busy     = (state != FETCH_A);
    assign data_out = sum_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH_A;
            a_reg     <= '0;
            sum_reg   <= '0;
            token_cnt <= '0;
            ovf       <= 1'b0;
        end else begin
            unique case (state)
                FETCH_A: if (!empty_a) state <= LATCH_A;
                LATCH_A: begin
                    a_reg <= data_a;
                    state <= FETCH_B;
                end
                FETCH_B: if (!empty_b) state <= LATCH_B;
                LATCH_B: begin
                    sum_reg <= core_sum;
                    if (core_carry) ovf <= 1'b1;
                    state   <= EMIT;
                end
                EMIT: if (!full_out) begin
                    token_cnt <= token_cnt + 1'b1;
                    state     <= FETCH_A;
                end
                default: state <= FETCH_A;
            endcase
        end
    end

endmodule

// File: tb/tb_kpn_add_process.sv
// Scoreboard bench for kpn_add_process: FIFO-like token queues feed the DUT,
// expected sums are queued at stimulus time and popped by a strobe monitor.
module tb_kpn_add_process;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        empty_a = 1'b1;
    logic [15:0] data_a = '0;
    logic        rd_a;
    logic        empty_b = 1'b1;
    logic [15:0] data_b = '0;
    logic        rd_b;
    logic        full_out = 1'b0;
    logic        wr_out;
    logic [15:0] data_out;
    logic [15:0] token_cnt;
    logic        ovf;
    logic        busy;

    kpn_add_process #(
        .WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .empty_a   (empty_a),
        .data_a    (data_a),
        .rd_a      (rd_a),
        .empty_b   (empty_b),
        .data_b    (data_b),
        .rd_b      (rd_b),
        .full_out  (full_out),
        .wr_out    (wr_out),
        .data_out  (data_out),
        .token_cnt (token_cnt),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        bit          c;
    } exp_t;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    exp_t        qexp[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int phase = 0;
    int cnt_m = 0;
    bit ovf_m = 1'b0;
    int na = 0;
    int nw = 0;
    int t_a = -1, t_b = -1, t_w = -1, t_ea = -1, t_f = -1;
    bit full_req = 1'b0;
    bit rand_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   t;
        t   = int'(a) + int'(b);
        e.c = (t > 65535);
`ifdef KPN_ADD_SATURATE_EN
        e.s = e.c ? 16'hFFFF : t[15:0];
`else
        e.s = t[15:0];
`endif
        return e;
    endfunction

    function automatic void push_pair(input logic [15:0] a, input logic [15:0] b);
        qa.push_back(a);
        qb.push_back(b);
        qexp.push_back(model(a, b));
    endfunction

    // FIFO status model: flags update just after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst_n && empty_a && qa.size() != 0) t_ea = cyc;
            empty_a = (qa.size() == 0);
            empty_b = (qb.size() == 0);
            if (full_out && !(rand_full ? ($urandom_range(0, 2) == 0) : full_req)) t_f = cyc;
            full_out = rand_full ? ($urandom_range(0, 2) == 0) : full_req;
        end
    end

    // Monitor: consumes strobes, serves pops, scores writes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rd_a || rd_b || wr_out)
                    chk("one_strobe", 32'($countones({rd_a, rd_b, wr_out})), 1);
                if (rd_a) begin
                    chk("order_rd_a", phase, 0);
                    chk("rd_a_when_empty", {31'b0, empty_a}, 0);
                    if (qa.size() != 0) data_a = qa.pop_front();
                    phase = 1; na++; t_a = cyc;
                end
                if (rd_b) begin
                    chk("order_rd_b", phase, 1);
                    chk("rd_b_when_empty", {31'b0, empty_b}, 0);
                    if (qb.size() != 0) data_b = qb.pop_front();
                    phase = 2; t_b = cyc;
                end
                if (wr_out) begin
                    chk("order_wr", phase, 2);
                    chk("wr_when_full", {31'b0, full_out}, 0);
                    if (qexp.size() == 0) begin
                        chk("unexpected_write", {16'b0, data_out}, 32'hFFFF_FFFF);
                    end else begin
                        e = qexp.pop_front();
                        ovf_m = ovf_m | e.c;
                        chk("data_out", {16'b0, data_out}, {16'b0, e.s});
                        chk("token_cnt", {16'b0, token_cnt}, cnt_m[15:0]);
                        chk("ovf", {31'b0, ovf}, {31'b0, ovf_m});
                        cnt_m = (cnt_m + 1) % 65536;
                    end
                    phase = 0; nw++; t_w = cyc;
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && (qexp.size() != 0 || phase != 0); i++) @(posedge clk);
        chk(name, qexp.size(), 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rd_a"}, {31'b0, rd_a}, 0);
        chk({tag, "_rd_b"}, {31'b0, rd_b}, 0);
        chk({tag, "_wr_out"}, {31'b0, wr_out}, 0);
        chk({tag, "_data_out"}, {16'b0, data_out}, 0);
        chk({tag, "_token_cnt"}, {16'b0, token_cnt}, 0);
        chk({tag, "_ovf"}, {31'b0, ovf}, 0);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
    endtask

    initial begin
        int na0, nw0;
        logic [15:0] ra, rb;

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Basic firing and latency
        @(posedge clk); #2;
        push_pair(16'd10, 16'd20);
        t_a = -1; t_b = -1; t_w = -1; t_ea = -1;
        wait_drain("drain_basic");
        chk("lat_rd_a", t_a - t_ea, 0);
        chk("lat_rd_b", t_b - t_a, 2);
        chk("lat_wr", t_w - t_a, 4);
        chk("cnt_after_basic", {16'b0, token_cnt}, 1);

        // Blocking read on B
        na0 = na; nw0 = nw;
        qa.push_back(16'd5);
        qexp.push_back(model(16'd5, 16'd7));
        repeat (12) @(posedge clk);
        #2;
        chk("rd_a_single_while_b_empty", na - na0, 1);
        chk("no_write_while_b_empty", nw - nw0, 0);
        qb.push_back(16'd7);
        wait_drain("drain_block");
        chk("block_write_once", nw - nw0, 1);

        // Output backpressure
        full_req = 1'b1;
        nw0 = nw; t_w = -1; t_f = -1;
        push_pair(16'd15, 16'd25);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("bp_no_write", nw - nw0, 0);
        chk("bp_hold_data", {16'b0, data_out}, 40);
        chk("bp_busy", {31'b0, busy}, 1);
        @(posedge clk); #2;
        full_req = 1'b0;
        wait_drain("drain_bp");
        chk("bp_wr_after_release", t_w - t_f, 0);
        chk("bp_write_once", nw - nw0, 1);

        // Overflow
        push_pair(16'hFFF0, 16'h0020);
        wait_drain("drain_ovf");
        chk("ovf_sticky", {31'b0, ovf}, 1);
`ifdef KPN_ADD_SATURATE_EN
        chk("ovf_sum", {16'b0, data_out}, 32'hFFFF);
`else
        chk("ovf_sum", {16'b0, data_out}, 32'h0010);
`endif

        // Reset while waiting in FETCH_B with A already popped
        qa.push_back(16'd9);
        repeat (6) @(posedge clk);
        #3;
        chk("mid_busy_before_reset", {31'b0, busy}, 1);
        rst_n = 1'b0;
        qa.delete(); qb.delete(); qexp.delete();
        phase = 0; cnt_m = 0; ovf_m = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("mid_reset");
        @(posedge clk); #3;
        rst_n = 1'b1;
        push_pair(16'd1, 16'd2);
        wait_drain("drain_after_reset");
        chk("cnt_after_reset", {16'b0, token_cnt}, 1);

        // Randomized traffic with random backpressure and skewed arrivals
        rand_full = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            qa.push_back(ra);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #2;
            qb.push_back(rb);
            qexp.push_back(model(ra, rb));
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #2;
        end
        wait_drain("drain_random");
        rand_full = 1'b0;
        chk("cnt_after_random", {16'b0, token_cnt}, 31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kpn_add_process.md
# kpn_add_process

KPN process node that sits directly downstream of two `fifo_module` channels and upstream of a third. Each firing does the following:
- Blocking-reads one token from channel A, then one token from channel B.
- Adds the two tokens.
- Blocking-writes the sum to the output channel.

It is the first arithmetic actor in the Kahn network and drives the `rd`/`wr` strobes of the FIFOs around it.

## Interface
Parameters:
- `WIDTH`, default 16: token width. Must match the FIFO `entry_1`/`output_1` width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low.
- `empty_a`, input, 1: channel A has no token.
- `data_a`, input, WIDTH: channel A `output_1`. Valid the cycle after `rd_a` is sampled high.
- `rd_a`, output, 1: read strobe to channel A.
- `empty_b`, input, 1: channel B has no token.
- `data_b`, input, WIDTH: channel B `output_1`. Same latency as `data_a`.
- `rd_b`, output, 1: read strobe to channel B.
- `full_out`, input, 1: output channel cannot accept a token.
- `wr_out`, output, 1: write strobe to the output channel.
- `data_out`, output, WIDTH: drives output channel `entry_1`.
- `token_cnt`, output, 16: number of tokens written since reset.
- `ovf`, output, 1: sticky flag, set when any sum carries out of WIDTH bits.
- `busy`, output, 1: high whenever the state is not FETCH_A.

## Operation
FSM states are FETCH_A, LATCH_A, FETCH_B, LATCH_B, EMIT. The reset state is FETCH_A.

- **FETCH_A:** `rd_a = !empty_a`. If `!empty_a`, go to LATCH_A; otherwise stay.
- **LATCH_A:** `a_reg <= data_a`, go to FETCH_B.
- **FETCH_B:** `rd_b = !empty_b`. If `!empty_b`, go to LATCH_B; otherwise stay.
  - Channel A is never read again while the node waits here. This preserves the KPN read order.
- **LATCH_B:** `sum_reg <= a_reg + data_b`, computed WIDTH+1 wide.
  - If carry is set, `ovf <= 1`.
  - Go to EMIT.
- **EMIT:** `wr_out = !full_out`. If `!full_out`, then `token_cnt <= token_cnt + 1` and go to FETCH_A; otherwise stay.
  - `data_out` holds `sum_reg` throughout EMIT.

Arithmetic and width rules:
- Unsigned addition; the result is the low WIDTH bits (mod 2^WIDTH).
- `token_cnt` wraps from 0xFFFF to 0x0000 with no flag.

Strobes:
- `rd_a`, `rd_b` and `wr_out` are decoded combinationally from state and flags.
- At most one strobe is high in any cycle.
- Each strobe is high for exactly one cycle per token.

## Timing
Reset values:
- `rd_a`, `rd_b`, `wr_out`: 0.
- `data_out`, `token_cnt`, `ovf`: 0.
- `busy`: 0.
- `a_reg`, `sum_reg`: 0.

Latency and throughput:
- Both inputs non-empty and output not full at cycle 0:
  - `rd_a` high in cycle 0.
  - `rd_b` high in cycle 2.
  - `wr_out` high in cycle 4, with the sum on `data_out`.
- Peak throughput is 1 token per 5 cycles.

Stalls and boundary conditions:
- An empty input stalls the node in the corresponding FETCH state for any number of cycles, with the strobe low.
- A full output stalls the node in EMIT with `data_out` stable.
- `empty_*` and `full_out` are sampled only in their own state and are ignored elsewhere.

Reset mid-operation:
- Asserting `rst_n` low in any state immediately returns the FSM to FETCH_A and clears all registers.
- A token already popped from channel A is discarded. This is accepted behaviour; the network is reset as a whole.

## Configuration
- `KPN_ADD_SATURATE_EN` defined: on carry out, `sum_reg` is clamped to all-ones (0xFFFF for WIDTH=16). `ovf` is still set.
- `KPN_ADD_SATURATE_EN` undefined: wrap-around sum. `ovf` is still set.

## Structure
- Shared package `kpn_pkg`:
  - state enum `kpn_add_state_t` (FETCH_A..EMIT);
  - `KPN_TOKEN_WIDTH = 16`;
  - `KPN_CNT_WIDTH = 16`.
- One sub-module, `kpn_add_core`: combinational WIDTH-bit adder returning sum and carry. It contains the saturation logic under the macro.
- The FSM and registers live in `kpn_add_process`.

## Test plan
1. **Reset:** hold `rst_n` low 3 cycles, then release.
   - All outputs 0, state FETCH_A, `busy` = 0.
2. **Basic firing:** A = 10, B = 20, output not full.
   - `rd_a` in cycle 0, `rd_b` in cycle 2, `wr_out` in cycle 4 with `data_out` = 30.
   - `token_cnt` = 1.
3. **Blocking read:** A = 5 available, B empty for 10 cycles, then B = 7.
   - `rd_a` is not re-asserted while waiting.
   - `data_out` = 12 written exactly once.
4. **Output backpressure:** `full_out` high for 6 cycles during EMIT with sum = 40.
   - `wr_out` stays low and `data_out` holds 40.
   - Single `wr_out` the cycle after `full_out` falls.
5. **Overflow:** A = 0xFFF0, B = 0x0020.
   - `ovf` = 1.
   - `data_out` = 0x0010 with the macro undefined; 0xFFFF with `KPN_ADD_SATURATE_EN` defined.
6. **Reset mid-operation:** assert `rst_n` low while in FETCH_B with A = 9 captured.
   - FSM returns to FETCH_A and `a_reg` = 0.
   - Next pair, A = 1 and B = 2, yields 3.
